// File: rtl/atm_pkg.sv
// Shared types and constants for the ATM account server and the ATM front-end FSM.
// Reset ledger contents live here so both sides agree on the boot-time account table.
package atm_pkg;

  localparam int NUM_ACCTS = 5;
  localparam int ID_W      = 3;
  localparam int AMT_W     = 12;
  localparam int BAL_W     = 18;
  localparam int DEP_LIMIT = 2000;
  localparam int MAX_TRIES = 3;
  localparam int IDX_W     = $clog2(NUM_ACCTS);
  localparam int TRY_W     = $clog2(MAX_TRIES + 1);

  typedef enum logic [1:0] {
    OP_BALANCE  = 2'b00,
    OP_DEPOSIT  = 2'b01,
    OP_WITHDRAW = 2'b10,
    OP_AUTH     = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_OK       = 3'd0,
    ST_BAD_CARD = 3'd1,
    ST_BAD_PIN  = 3'd2,
    ST_LOCKED   = 3'd3,
    ST_LIMIT    = 3'd4,
    ST_NO_FUNDS = 3'd5
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_EXEC   = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  typedef logic [ID_W-1:0]                  id_t;
  typedef logic [BAL_W-1:0]                 bal_t;
  typedef logic [NUM_ACCTS-1:0][ID_W-1:0]   id_tbl_t;
  typedef logic [NUM_ACCTS-1:0][BAL_W-1:0]  bal_tbl_t;

  // Entry 0 is the rightmost element of each concatenation.
  localparam id_tbl_t  RST_IDS  = {3'd5, 3'd4, 3'd3, 3'd2, 3'd1};
  localparam id_tbl_t  RST_PINS = {3'd5, 3'd4, 3'd3, 3'd2, 3'd1};
  localparam bal_tbl_t RST_BALS = {18'd120000, 18'd140000, 18'd135000, 18'd130000, 18'd125000};

endpackage

// File: rtl/atm_account_server_if.sv
// Request/response channel between the ATM front-end (master) and the account server (slave).
interface atm_account_server_if;
  import atm_pkg::*;

  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  id_t              req_card;
  id_t              req_pin;
  logic [AMT_W-1:0] req_amount;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [2:0]       rsp_status;
  bal_t             rsp_balance;

  modport master (
    output req_valid, req_op, req_card, req_pin, req_amount, rsp_ready,
    input  req_ready, rsp_valid, rsp_status, rsp_balance
  );

  modport slave (
    input  req_valid, req_op, req_card, req_pin, req_amount, rsp_ready,
    output req_ready, rsp_valid, rsp_status, rsp_balance
  );

endinterface

// File: rtl/atm_acct_lookup.sv
// Parallel card-ID match against the ledger ID table; lowest matching index wins.
module atm_acct_lookup
  import atm_pkg::*;
(
  input  id_t              card,
  input  id_tbl_t          ids,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);

  // Scan from the top so a lower duplicate overrides a higher one.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_ACCTS - 1; i >= 0; i--) begin
      if (ids[i] == card) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/atm_account_server.sv
// Bank-side account server: owns balances, PIN fail counters and lock bits, one request at a time.
// state    | meaning
// S_IDLE   | req_ready high, waiting for a request
// S_LOOKUP | register card match (hit, index)
// S_EXEC   | decide status, commit at most one ledger entry
// S_RESP   | hold response until rsp_ready
module atm_account_server
  import atm_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  atm_account_server_if.slave bus
);

  state_e                          state_q, state_d;
  op_e                             op_q, op_d;
  id_t                             card_q, card_d;
  id_t                             pin_q, pin_d;
  logic [AMT_W-1:0]                amt_q, amt_d;
  logic                            hit_q, hit_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  bal_tbl_t                        bal_q, bal_d;
  logic [NUM_ACCTS-1:0][TRY_W-1:0] tries_q, tries_d;
  logic [NUM_ACCTS-1:0]            lock_q, lock_d;
  logic                            req_ready_q, req_ready_d;
  logic                            rsp_valid_q, rsp_valid_d;
  status_e                         rsp_status_q, rsp_status_d;
  bal_t                            rsp_balance_q, rsp_balance_d;

  id_tbl_t          id_tbl;
  id_tbl_t          pin_tbl;
  logic             lu_hit;
  logic [IDX_W-1:0] lu_idx;
  bal_t             cur_bal;
  bal_t             amt_ext;
  logic [BAL_W:0]   dep_sum;
  logic [TRY_W-1:0] tries_inc;

  assign id_tbl  = RST_IDS;
  assign pin_tbl = RST_PINS;

  atm_acct_lookup u_lookup (
    .card (card_q),
    .ids  (id_tbl),
    .hit  (lu_hit),
    .idx  (lu_idx)
  );

  assign cur_bal   = bal_q[idx_q];
  assign amt_ext   = BAL_W'(amt_q);
  assign dep_sum   = {1'b0, cur_bal} + {1'b0, amt_ext};
  assign tries_inc = tries_q[idx_q] + TRY_W'(1);

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    card_d        = card_q;
    pin_d         = pin_q;
    amt_d         = amt_q;
    hit_d         = hit_q;
    idx_d         = idx_q;
    bal_d         = bal_q;
    tries_d       = tries_q;
    lock_d        = lock_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_status_d  = rsp_status_q;
    rsp_balance_d = rsp_balance_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          op_d    = op_e'(bus.req_op);
          card_d  = bus.req_card;
          pin_d   = bus.req_pin;
          amt_d   = bus.req_amount;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        hit_d   = lu_hit;
        idx_d   = lu_idx;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d       = S_RESP;
        rsp_valid_d   = 1'b1;
        rsp_balance_d = '0;
        if (!hit_q) begin
          rsp_status_d = ST_BAD_CARD;
        end else if (lock_q[idx_q]) begin
          rsp_status_d = ST_LOCKED;
        end else if (pin_q != pin_tbl[idx_q]) begin
          // The response that trips the lock still reports BAD_PIN.
          rsp_status_d   = ST_BAD_PIN;
          tries_d[idx_q] = tries_inc;
          if (tries_inc == TRY_W'(MAX_TRIES)) lock_d[idx_q] = 1'b1;
        end else begin
          tries_d[idx_q] = '0;
          rsp_status_d   = ST_OK;
          rsp_balance_d  = cur_bal;
          case (op_q)
            OP_DEPOSIT: begin
              if (amt_q > AMT_W'(DEP_LIMIT) || dep_sum[BAL_W]) begin
                rsp_status_d = ST_LIMIT;
              end else begin
                bal_d[idx_q]  = dep_sum[BAL_W-1:0];
                rsp_balance_d = dep_sum[BAL_W-1:0];
              end
            end
            OP_WITHDRAW: begin
              if (amt_ext > cur_bal) begin
                rsp_status_d = ST_NO_FUNDS;
              end else begin
                bal_d[idx_q]  = cur_bal - amt_ext;
                rsp_balance_d = cur_bal - amt_ext;
              end
            end
            default: ;
          endcase
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    req_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      op_q          <= OP_BALANCE;
      card_q        <= '0;
      pin_q         <= '0;
      amt_q         <= '0;
      hit_q         <= 1'b0;
      idx_q         <= '0;
      bal_q         <= RST_BALS;
      tries_q       <= '0;
      lock_q        <= '0;
      req_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_status_q  <= ST_OK;
      rsp_balance_q <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      card_q        <= card_d;
      pin_q         <= pin_d;
      amt_q         <= amt_d;
      hit_q         <= hit_d;
      idx_q         <= idx_d;
      bal_q         <= bal_d;
      tries_q       <= tries_d;
      lock_q        <= lock_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_status_q  <= rsp_status_d;
      rsp_balance_q <= rsp_balance_d;
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_status  = rsp_status_q;
  assign bus.rsp_balance = rsp_balance_q;

endmodule

// File: tb/tb_atm_account_server.sv
// Directed testbench for atm_account_server: ledger ops, PIN lockout, limits, handshake and reset.
module tb_atm_account_server;

  localparam logic [1:0] OPB = 2'b00, OPD = 2'b01, OPW = 2'b10, OPA = 2'b11;
  localparam logic [2:0] S_OK = 3'd0, S_BCARD = 3'd1, S_BPIN = 3'd2, S_LOCK = 3'd3,
                         S_LIM = 3'd4, S_NOF = 3'd5;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  atm_account_server_if bus();

  atm_account_server dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic do_txn(input logic [1:0] op, input logic [2:0] card, input logic [2:0] pin,
                        input logic [11:0] amt, output logic [2:0] st, output logic [17:0] bal,
                        output int lat, output int acc_cyc);
    int guard;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_op     = op;
    bus.req_card   = card;
    bus.req_pin    = pin;
    bus.req_amount = amt;
    guard = 0;
    while (bus.req_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    // Scramble inputs after the accept edge; the server must not resample them.
    bus.req_valid  = 1'b0;
    bus.req_op     = ~op;
    bus.req_card   = ~card;
    bus.req_pin    = ~pin;
    bus.req_amount = ~amt;
    lat = 0;
    while (bus.rsp_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (lat >= 20) begin
      tests++;
      fails++;
      $display("FAIL rsp_timeout: rsp_valid=%b after %0d cycles, want 1", bus.rsp_valid, lat);
    end
    st  = bus.rsp_status;
    bal = bus.rsp_balance;
  endtask

  task automatic finish_rsp;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic txn(input logic [1:0] op, input logic [2:0] card, input logic [2:0] pin,
                     input logic [11:0] amt, output logic [2:0] st, output logic [17:0] bal);
    int lat, acc;
    do_txn(op, card, pin, amt, st, bal, lat, acc);
    finish_rsp();
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #12;
    tests++;
    if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.rsp_status !== 3'd0 ||
        bus.rsp_balance !== 18'd0) begin
      fails++;
      $display("FAIL reset_outputs: req_ready=%b rsp_valid=%b status=%0d bal=%0d, want 0/0/0/0",
               bus.req_ready, bus.rsp_valid, bus.rsp_status, bus.rsp_balance);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (bus.req_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_ready: req_ready=%b, want 1", bus.req_ready);
    end
  endtask

  task automatic test_balance;
    logic [2:0] st;
    logic [17:0] bal;
    int lat, acc;
    do_txn(OPB, 3'd2, 3'd2, 12'd0, st, bal, lat, acc);
    tests++;
    if (st !== S_OK || bal !== 18'd130000) begin
      fails++;
      $display("FAIL balance_c2: status=%0d bal=%0d, want 0/130000", st, bal);
    end
    tests++;
    if (lat !== 2) begin
      fails++;
      $display("FAIL balance_latency: edges after accept=%0d, want 2", lat);
    end
    finish_rsp();
    txn(OPA, 3'd2, 3'd2, 12'd55, st, bal);
    tests++;
    if (st !== S_OK || bal !== 18'd130000) begin
      fails++;
      $display("FAIL auth_c2: status=%0d bal=%0d, want 0/130000", st, bal);
    end
  endtask

  task automatic test_deposit;
    logic [2:0] st;
    logic [17:0] bal;
    logic bad;
    txn(OPD, 3'd1, 3'd1, 12'd2000, st, bal);
    tests++;
    if (st !== S_OK || bal !== 18'd127000) begin
      fails++;
      $display("FAIL deposit_2000: status=%0d bal=%0d, want 0/127000", st, bal);
    end
    txn(OPD, 3'd1, 3'd1, 12'd2001, st, bal);
    tests++;
    if (st !== S_LIM || bal !== 18'd127000) begin
      fails++;
      $display("FAIL deposit_2001: status=%0d bal=%0d, want 4/127000", st, bal);
    end
    // Walk card 2 up to the top of the balance range.
    bad = 1'b0;
    for (int k = 1; k <= 66; k++) begin
      txn(OPD, 3'd2, 3'd2, 12'd2000, st, bal);
      if (st !== S_OK || bal !== 18'(130000 + 2000 * k)) bad = 1'b1;
    end
    tests++;
    if (bad || bal !== 18'd262000) begin
      fails++;
      $display("FAIL deposit_ramp: last status=%0d bal=%0d, want 0/262000", st, bal);
    end
    txn(OPD, 3'd2, 3'd2, 12'd144, st, bal);
    tests++;
    if (st !== S_LIM || bal !== 18'd262000) begin
      fails++;
      $display("FAIL deposit_overflow: status=%0d bal=%0d, want 4/262000", st, bal);
    end
    txn(OPD, 3'd2, 3'd2, 12'd143, st, bal);
    tests++;
    if (st !== S_OK || bal !== 18'd262143) begin
      fails++;
      $display("FAIL deposit_to_max: status=%0d bal=%0d, want 0/262143", st, bal);
    end
  endtask

  task automatic test_withdraw;
    logic [2:0] st;
    logic [17:0] bal;
    logic bad;
    bad = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      txn(OPW, 3'd5, 3'd5, 12'd4000, st, bal);
      if (st !== S_OK || bal !== 18'(120000 - 4000 * k)) bad = 1'b1;
    end
    tests++;
    if (bad || bal !== 18'd0) begin
      fails++;
      $display("FAIL withdraw_to_zero: last status=%0d bal=%0d, want 0/0", st, bal);
    end
    txn(OPW, 3'd5, 3'd5, 12'd1, st, bal);
    tests++;
    if (st !== S_NOF || bal !== 18'd0) begin
      fails++;
      $display("FAIL withdraw_no_funds: status=%0d bal=%0d, want 5/0", st, bal);
    end
    txn(OPW, 3'd5, 3'd5, 12'd0, st, bal);
    tests++;
    if (st !== S_OK || bal !== 18'd0) begin
      fails++;
      $display("FAIL withdraw_zero: status=%0d bal=%0d, want 0/0", st, bal);
    end
  endtask

  task automatic test_lockout;
    logic [2:0] st;
    logic [17:0] bal;
    for (int k = 0; k < 3; k++) begin
      txn(OPB, 3'd3, 3'd7, 12'd0, st, bal);
      tests++;
      if (st !== S_BPIN || bal !== 18'd0) begin
        fails++;
        $display("FAIL bad_pin_%0d: status=%0d bal=%0d, want 2/0", k, st, bal);
      end
    end
    txn(OPB, 3'd3, 3'd3, 12'd0, st, bal);
    tests++;
    if (st !== S_LOCK || bal !== 18'd0) begin
      fails++;
      $display("FAIL locked_good_pin: status=%0d bal=%0d, want 3/0", st, bal);
    end
    txn(OPB, 3'd6, 3'd6, 12'd0, st, bal);
    tests++;
    if (st !== S_BCARD || bal !== 18'd0) begin
      fails++;
      $display("FAIL bad_card_6: status=%0d bal=%0d, want 1/0", st, bal);
    end
    txn(OPD, 3'd0, 3'd0, 12'd10, st, bal);
    tests++;
    if (st !== S_BCARD || bal !== 18'd0) begin
      fails++;
      $display("FAIL bad_card_0: status=%0d bal=%0d, want 1/0", st, bal);
    end
  endtask

  task automatic test_counter_clear;
    logic [2:0] st;
    logic [17:0] bal;
    logic bad;
    bad = 1'b0;
    for (int k = 0; k < 2; k++) begin
      txn(OPB, 3'd4, 3'd1, 12'd0, st, bal);
      if (st !== S_BPIN || bal !== 18'd0) bad = 1'b1;
    end
    txn(OPA, 3'd4, 3'd4, 12'd0, st, bal);
    tests++;
    if (bad || st !== S_OK || bal !== 18'd140000) begin
      fails++;
      $display("FAIL clear_auth: status=%0d bal=%0d badpin_err=%b, want 0/140000/0", st, bal, bad);
    end
    bad = 1'b0;
    for (int k = 0; k < 2; k++) begin
      txn(OPB, 3'd4, 3'd1, 12'd0, st, bal);
      if (st !== S_BPIN || bal !== 18'd0) bad = 1'b1;
    end
    txn(OPB, 3'd4, 3'd4, 12'd0, st, bal);
    tests++;
    if (bad || st !== S_OK || bal !== 18'd140000) begin
      fails++;
      $display("FAIL clear_not_locked: status=%0d bal=%0d badpin_err=%b, want 0/140000/0", st, bal, bad);
    end
  endtask

  task automatic test_hold;
    logic [2:0] st;
    logic [17:0] bal;
    int lat, acc;
    bus.rsp_ready = 1'b0;
    do_txn(OPB, 3'd2, 3'd2, 12'd0, st, bal, lat, acc);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      tests++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_status !== S_OK || bus.rsp_balance !== 18'd262143 ||
          bus.req_ready !== 1'b0) begin
        fails++;
        $display("FAIL hold_%0d: valid=%b status=%0d bal=%0d req_ready=%b, want 1/0/262143/0",
                 i, bus.rsp_valid, bus.rsp_status, bus.rsp_balance, bus.req_ready);
      end
    end
    finish_rsp();
    tests++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      fails++;
      $display("FAIL hold_release: valid=%b req_ready=%b, want 0/1", bus.rsp_valid, bus.req_ready);
    end
  endtask

  task automatic test_back_to_back;
    logic [2:0] st1, st2;
    logic [17:0] bal1, bal2;
    int lat, acc1, acc2;
    do_txn(OPB, 3'd1, 3'd1, 12'd0, st1, bal1, lat, acc1);
    finish_rsp();
    do_txn(OPA, 3'd4, 3'd4, 12'd0, st2, bal2, lat, acc2);
    finish_rsp();
    tests++;
    if (st1 !== S_OK || bal1 !== 18'd127000 || st2 !== S_OK || bal2 !== 18'd140000) begin
      fails++;
      $display("FAIL b2b_results: %0d/%0d and %0d/%0d, want 0/127000 and 0/140000",
               st1, bal1, st2, bal2);
    end
    tests++;
    if (acc2 - acc1 !== 4) begin
      fails++;
      $display("FAIL b2b_spacing: accept gap=%0d cycles, want 4", acc2 - acc1);
    end
  endtask

  task automatic test_reset_mid_exec;
    logic [2:0] st;
    logic [17:0] bal;
    logic seen;
    int guard;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_op     = OPD;
    bus.req_card   = 3'd1;
    bus.req_pin    = 3'd1;
    bus.req_amount = 12'd1000;
    guard = 0;
    while (bus.req_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #2;
    tests++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin
      fails++;
      $display("FAIL rst_exec_outputs: valid=%b req_ready=%b, want 0/0", bus.rsp_valid, bus.req_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid !== 1'b0) seen = 1'b1;
    end
    tests++;
    if (seen) begin
      fails++;
      $display("FAIL rst_exec_no_rsp: rsp_valid seen=1, want 0");
    end
    txn(OPB, 3'd1, 3'd1, 12'd0, st, bal);
    tests++;
    if (st !== S_OK || bal !== 18'd125000) begin
      fails++;
      $display("FAIL rst_ledger_c1: status=%0d bal=%0d, want 0/125000", st, bal);
    end
    txn(OPB, 3'd3, 3'd3, 12'd0, st, bal);
    tests++;
    if (st !== S_OK || bal !== 18'd135000) begin
      fails++;
      $display("FAIL rst_unlock_c3: status=%0d bal=%0d, want 0/135000", st, bal);
    end
    txn(OPB, 3'd5, 3'd5, 12'd0, st, bal);
    tests++;
    if (st !== S_OK || bal !== 18'd120000) begin
      fails++;
      $display("FAIL rst_ledger_c5: status=%0d bal=%0d, want 0/120000", st, bal);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_op     = 2'b00;
    bus.req_card   = 3'd0;
    bus.req_pin    = 3'd0;
    bus.req_amount = 12'd0;
    bus.rsp_ready  = 1'b1;
    test_reset();
    test_balance();
    test_deposit();
    test_withdraw();
    test_lockout();
    test_counter_clear();
    test_hold();
    test_back_to_back();
    test_reset_mid_exec();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
